// File: rtl/cl_pixel_unpacker.sv
// Camera Link top/btm tap unpacker: bit-residue unpacking, dark subtraction, column/row/frame tagging.
// Define CL_UNPACK_SAT_EN to clamp dn<dark to zero; otherwise the subtraction wraps modulo 2^DN_SIZE.
module cl_pixel_unpacker #(
  parameter int DN_SIZE      = 12,
  parameter int N_PORT       = 5,
  parameter int N_COL_SIZE   = 12,
  parameter int N_ROW_SIZE   = 11,
  parameter int N_FRAME_SIZE = 20,
  localparam int W_IN    = 8 * N_PORT,
  localparam int MAX_PIX = (W_IN + DN_SIZE - 1) / DN_SIZE,
  localparam int RES_W   = $clog2(DN_SIZE),
  localparam int LANE_W  = MAX_PIX * DN_SIZE
) (
  input  logic                      clk_85,
  input  logic                      reset,
  input  logic                      cl_fval,
  input  logic                      cl_lval,
  input  logic [W_IN-1:0]           cl_top,
  input  logic [W_IN-1:0]           cl_btm,
  input  logic [2*LANE_W-1:0]       coeff_data,
  input  logic                      coeff_empty,
  output logic                      coeff_rd,
  input  logic                      error_clr,
  output logic [MAX_PIX-1:0]        pix_valid,
  output logic [LANE_W-1:0]         e_top,
  output logic [LANE_W-1:0]         e_btm,
  output logic [N_COL_SIZE-1:0]     l_col,
  output logic [N_COL_SIZE-1:0]     r_col,
  output logic [N_ROW_SIZE-1:0]     row,
  output logic [N_FRAME_SIZE-1:0]   frame,
  output logic                      frame_end,
  output logic                      error,
  output logic                      line_misalign
);

  localparam int CW = W_IN + DN_SIZE - 1;
  localparam int TW = $clog2(CW + 1);
  localparam int NW = $clog2(MAX_PIX + 1);
  localparam logic [RES_W-1:0] RES_MAX = RES_W'(DN_SIZE - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_INTERLINE, ST_LINE, ST_ERROR} state_t;

  state_t                    state_q, state_d;
  logic                      fval_q, fval_d;
  logic [N_ROW_SIZE-1:0]     row_q, row_d;
  logic [N_FRAME_SIZE-1:0]   frame_q, frame_d;
  logic                      frame_end_q, frame_end_d;
  logic                      misalign_q, misalign_d;
  logic [MAX_PIX-1:0]        pix_valid_q, pix_valid_d;
  logic [N_COL_SIZE-1:0]     l_col_q, l_col_d, r_col_q, r_col_d;
  logic [N_COL_SIZE-1:0]     next_col_q, next_col_d;
  logic [LANE_W-1:0]         e_top_q, e_top_d, e_btm_q, e_btm_d;
  logic [RES_W-1:0]          res_n_q, res_n_d;
  logic [DN_SIZE-2:0]        top_res_q, top_res_d, btm_res_q, btm_res_d;

  logic [CW-1:0]             top_word, btm_word, top_al, btm_al, res_mask, top_left, btm_left;
  logic [RES_W-1:0]          shift_amt, res_n_next;
  logic [TW-1:0]             tot_bits;
  logic [NW-1:0]             n_pix;
  logic [LANE_W-1:0]         top_dn, btm_dn;
  logic                      beat, err_cond;

  function automatic logic [DN_SIZE-1:0] dark_sub(input logic [DN_SIZE-1:0] dn,
                                                  input logic [DN_SIZE-1:0] dark);
`ifdef CL_UNPACK_SAT_EN
    return (dn < dark) ? '0 : dn - dark;
`else
    return dn - dark;
`endif
  endfunction

  assign err_cond = cl_lval && (coeff_empty || !cl_fval);
  assign beat     = cl_lval && cl_fval && !coeff_empty &&
                    (state_q == ST_INTERLINE || state_q == ST_LINE);
  assign coeff_rd = beat;

  // Left-align {residue, taps} so pixel k always sits at a fixed offset from the MSB.
  always_comb begin
    top_word   = {top_res_q, cl_top};
    btm_word   = {btm_res_q, cl_btm};
    shift_amt  = RES_MAX - res_n_q;
    top_al     = top_word << shift_amt;
    btm_al     = btm_word << shift_amt;
    tot_bits   = TW'(res_n_q) + TW'(W_IN);
    n_pix      = NW'(tot_bits / TW'(DN_SIZE));
    res_n_next = RES_W'(tot_bits % TW'(DN_SIZE));
    res_mask   = (CW'(1) << res_n_next) - CW'(1);
    top_left   = top_word & res_mask;
    btm_left   = btm_word & res_mask;
    top_dn     = '0;
    btm_dn     = '0;
    for (int k = 0; k < MAX_PIX; k++) begin
      top_dn[k*DN_SIZE +: DN_SIZE] = top_al[CW-1-k*DN_SIZE -: DN_SIZE];
      btm_dn[k*DN_SIZE +: DN_SIZE] = btm_al[CW-1-k*DN_SIZE -: DN_SIZE];
    end
  end

  always_comb begin
    state_d     = state_q;
    fval_d      = cl_fval;
    row_d       = row_q;
    frame_d     = frame_q;
    frame_end_d = 1'b0;
    misalign_d  = misalign_q;
    pix_valid_d = '0;
    l_col_d     = '1;
    r_col_d     = '1;
    e_top_d     = e_top_q;
    e_btm_d     = e_btm_q;
    next_col_d  = '0;
    res_n_d     = '0;
    top_res_d   = '0;
    btm_res_d   = '0;

    if (error_clr && !cl_fval) misalign_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (err_cond) state_d = ST_ERROR;
        else if (cl_fval && !fval_q) begin
          state_d = ST_INTERLINE;
          row_d   = '0;
        end
      end
      ST_INTERLINE: begin
        if (err_cond) state_d = ST_ERROR;
        else if (!cl_fval) begin
          state_d     = ST_IDLE;
          frame_end_d = 1'b1;
          frame_d     = frame_q + N_FRAME_SIZE'(1);
          row_d       = '0;
        end else if (cl_lval) state_d = ST_LINE;
      end
      ST_LINE: begin
        if (err_cond) state_d = ST_ERROR;
        else if (!cl_lval) begin
          if (res_n_q != '0) misalign_d = 1'b1;
          if (!cl_fval) begin
            state_d     = ST_IDLE;
            frame_end_d = 1'b1;
            frame_d     = frame_q + N_FRAME_SIZE'(1);
            row_d       = '0;
          end else begin
            state_d = ST_INTERLINE;
            row_d   = row_q + N_ROW_SIZE'(1);
          end
        end
      end
      ST_ERROR: begin
        if (error_clr && !cl_fval) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Any cycle that is not an accepted beat discards the partial pixel and restarts columns.
    if (beat) begin
      for (int k = 0; k < MAX_PIX; k++) begin
        if (NW'(k) < n_pix) pix_valid_d[k] = 1'b1;
        e_top_d[k*DN_SIZE +: DN_SIZE] = dark_sub(top_dn[k*DN_SIZE +: DN_SIZE],
                                                 coeff_data[k*DN_SIZE +: DN_SIZE]);
        e_btm_d[k*DN_SIZE +: DN_SIZE] = dark_sub(btm_dn[k*DN_SIZE +: DN_SIZE],
                                                 coeff_data[LANE_W + k*DN_SIZE +: DN_SIZE]);
      end
      l_col_d    = next_col_q;
      r_col_d    = next_col_q + N_COL_SIZE'(n_pix) - N_COL_SIZE'(1);
      next_col_d = next_col_q + N_COL_SIZE'(n_pix);
      res_n_d    = res_n_next;
      top_res_d  = top_left[DN_SIZE-2:0];
      btm_res_d  = btm_left[DN_SIZE-2:0];
    end
  end

  // fval_q resets high so a line in progress at reset release is not picked up mid-way.
  always_ff @(posedge clk_85 or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      fval_q      <= 1'b1;
      row_q       <= '0;
      frame_q     <= '0;
      frame_end_q <= 1'b0;
      misalign_q  <= 1'b0;
      pix_valid_q <= '0;
      l_col_q     <= '1;
      r_col_q     <= '1;
      next_col_q  <= '0;
      e_top_q     <= '0;
      e_btm_q     <= '0;
      res_n_q     <= '0;
      top_res_q   <= '0;
      btm_res_q   <= '0;
    end else begin
      state_q     <= state_d;
      fval_q      <= fval_d;
      row_q       <= row_d;
      frame_q     <= frame_d;
      frame_end_q <= frame_end_d;
      misalign_q  <= misalign_d;
      pix_valid_q <= pix_valid_d;
      l_col_q     <= l_col_d;
      r_col_q     <= r_col_d;
      next_col_q  <= next_col_d;
      e_top_q     <= e_top_d;
      e_btm_q     <= e_btm_d;
      res_n_q     <= res_n_d;
      top_res_q   <= top_res_d;
      btm_res_q   <= btm_res_d;
    end
  end

  assign pix_valid     = pix_valid_q;
  assign e_top         = e_top_q;
  assign e_btm         = e_btm_q;
  assign l_col         = l_col_q;
  assign r_col         = r_col_q;
  assign row           = row_q;
  assign frame         = frame_q;
  assign frame_end     = frame_end_q;
  assign error         = (state_q == ST_ERROR);
  assign line_misalign = misalign_q;

endmodule
